// File: rtl/any1_pkg.sv
// Shared types for the ANY1 front end: the decoded-instruction payload and
// decode-queue sizing defaults.
package any1_pkg;

  localparam int unsigned AQ_DEPTH = 4;
  localparam int unsigned AQ_SW    = 3;

  typedef struct packed {
    logic [31:0] val;
  } sImm;

  typedef struct packed {
    logic [AQ_SW-1:0] Stream;
    logic             Stream_inc;
    logic [31:0]      ip;
    logic             ui;
    logic             rfwr;
    logic             vrfwr;
    sImm              imm;
    logic             branch;
    logic             predict_taken;
    logic [5:0]       Rt;
  } sDecode;

  // Idle head value: an empty slot reads as an unimplemented instruction.
  function automatic sDecode dec_idle();
    sDecode d;
    d    = '0;
    d.ui = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/any1_dq_ram.sv
// Decode-queue storage: DEPTH entries, one synchronous write port and one
// asynchronous read port. Contents are not reset.
module any1_dq_ram
  import any1_pkg::*;
#(
  parameter int unsigned DEPTH = AQ_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  sDecode        i_wdata,
  input  logic [AW-1:0] i_raddr,
  output sDecode        o_rdata
);

  sDecode r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/any1_decode_queue.sv
// Elastic decode-to-issue queue with a registered head, flush, stale-stream
// drop and a sticky overflow flag.
module any1_decode_queue
  import any1_pkg::*;
#(
  parameter int unsigned DEPTH = AQ_DEPTH,
  parameter int unsigned SW    = AQ_SW
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       dec_v_i,
  input  sDecode                     dec_i,
  output logic                       dec_rdy_o,
  output logic                       iq_v_o,
  output sDecode                     iq_o,
  input  logic                       iq_rdy_i,
  input  logic                       flush_i,
  input  logic [SW-1:0]              cur_stream_i,
  output logic [$clog2(DEPTH+1)-1:0] cnt_o,
  output logic                       ovf_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_dec_rdy, r_iq_v, r_ovf;
  sDecode        r_iq;

  logic          w_enq, w_deq, w_bypass;
  logic [PW-1:0] w_rd_next, w_wr_next;
  logic [CW-1:0] w_cnt_next;
  sDecode        w_ram_rd, w_head;

  any1_dq_ram #(.DEPTH(DEPTH), .AW(PW)) u_ram (
    .i_clk   (clk_i),
    .i_we    (w_enq),
    .i_waddr (r_wr_ptr),
    .i_wdata (dec_i),
    .i_raddr (w_rd_next),
    .o_rdata (w_ram_rd)
  );

  // Next-state control; flush overrides enqueue and dequeue.
  always_comb begin
    w_enq      = dec_v_i && r_dec_rdy && !flush_i
                 && (dec_i.Stream == AQ_SW'(cur_stream_i));
    w_deq      = r_iq_v && iq_rdy_i && !flush_i;
    w_rd_next  = r_rd_ptr;
    w_wr_next  = r_wr_ptr;
    w_cnt_next = r_cnt;
    if (flush_i) begin
      w_rd_next  = '0;
      w_wr_next  = '0;
      w_cnt_next = '0;
    end else begin
      w_rd_next  = r_rd_ptr + PW'(w_deq);
      w_wr_next  = r_wr_ptr + PW'(w_enq);
      w_cnt_next = r_cnt + CW'(w_enq) - CW'(w_deq);
    end
    // An entry written this edge into a drained queue is not yet in the RAM.
    w_bypass = w_enq && ((r_cnt - CW'(w_deq)) == '0);
    w_head   = w_bypass ? dec_i : w_ram_rd;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_cnt     <= '0;
      r_dec_rdy <= 1'b1;
      r_iq_v    <= 1'b0;
      r_iq      <= dec_idle();
      r_ovf     <= 1'b0;
    end else begin
      r_rd_ptr  <= w_rd_next;
      r_wr_ptr  <= w_wr_next;
      r_cnt     <= w_cnt_next;
      r_dec_rdy <= (w_cnt_next != CW'(DEPTH));
      r_iq_v    <= (w_cnt_next != '0);
      r_iq      <= w_head;
      if (dec_v_i && !r_dec_rdy && !flush_i) r_ovf <= 1'b1;
    end
  end

  assign dec_rdy_o = r_dec_rdy;
  assign iq_v_o    = r_iq_v;
  assign iq_o      = r_iq;
  assign cnt_o     = r_cnt;
  assign ovf_o     = r_ovf;

endmodule

// File: tb/tb_any1_decode_queue.sv
// Directed self-checking bench for any1_decode_queue.
module tb_any1_decode_queue;
  import any1_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         dec_v;
  sDecode       dec;
  logic         dec_rdy;
  logic         iq_v;
  sDecode       iq;
  logic         iq_rdy;
  logic         flush;
  logic [2:0]   cur_stream;
  logic [2:0]   cnt;
  logic         ovf;

  int n_cmp = 0;
  int n_mis = 0;

  any1_decode_queue #(.DEPTH(4), .SW(3)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .dec_v_i      (dec_v),
    .dec_i        (dec),
    .dec_rdy_o    (dec_rdy),
    .iq_v_o       (iq_v),
    .iq_o         (iq),
    .iq_rdy_i     (iq_rdy),
    .flush_i      (flush),
    .cur_stream_i (cur_stream),
    .cnt_o        (cnt),
    .ovf_o        (ovf)
  );

  always #5 clk = ~clk;

  function automatic sDecode mk(input logic [31:0] ip, input logic [2:0] s);
    sDecode d;
    d               = '0;
    d.ip            = ip;
    d.Stream        = s;
    d.ui            = ip[2];
    d.rfwr          = ip[3];
    d.vrfwr         = ~ip[3];
    d.imm.val       = {ip[15:0], 16'hBEEF};
    d.branch        = ip[4];
    d.predict_taken = ip[5];
    d.Stream_inc    = ip[6];
    d.Rt            = ip[7:2];
    return d;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #12;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; dec_v = 1'b0; dec = '0; iq_rdy = 1'b0; flush = 1'b0; cur_stream = 3'd0;
    #12;
    chk("rst_cnt",  128'(cnt), 128'(3'd0));
    chk("rst_iqv",  128'(iq_v), 128'(1'b0));
    chk("rst_rdy",  128'(dec_rdy), 128'(1'b1));
    chk("rst_ovf",  128'(ovf), 128'(1'b0));
    chk("rst_iq",   128'(iq), 128'(dec_idle()));
    rst = 1'b0;
    step();

    // Basic fill, head held while issue stalls
    for (int i = 0; i < 4; i++) begin
      dec_v = 1'b1; dec = mk(32'h100 + 32'(4*i), 3'd0);
      step();
      chk("fill_head", 128'(iq.ip), 128'(32'h100));
    end
    dec_v = 1'b0;
    chk("fill_cnt", 128'(cnt), 128'(3'd4));
    chk("fill_rdy", 128'(dec_rdy), 128'(1'b0));
    chk("fill_iq",  128'(iq), 128'(mk(32'h100, 3'd0)));
    iq_rdy = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      chk("drain_ip", 128'(iq.ip), 128'(32'h100 + 32'(4*i)));
      chk("drain_v",  128'(iq_v), 128'(1'b1));
    end
    step();
    chk("drain_empty_v", 128'(iq_v), 128'(1'b0));
    chk("drain_empty_c", 128'(cnt), 128'(3'd0));

    // Streaming: 1-cycle latency, 1/cycle throughput
    for (int i = 0; i < 5; i++) begin
      dec_v = 1'b1; dec = mk(32'h300 + 32'(4*i), 3'd0);
      step();
      chk("strm_ip",  128'(iq.ip), 128'(32'h300 + 32'(4*i)));
      chk("strm_cnt", 128'(cnt), 128'(3'd1));
    end
    dec_v = 1'b0;
    step();
    chk("strm_end_v", 128'(iq_v), 128'(1'b0));

    // Full with simultaneous dequeue: offer refused, overflow flagged
    iq_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dec_v = 1'b1; dec = mk(32'h400 + 32'(4*i), 3'd0);
      step();
    end
    dec = mk(32'h4F0, 3'd0); iq_rdy = 1'b1;
    step();
    dec_v = 1'b0; iq_rdy = 1'b0;
    chk("full_cnt", 128'(cnt), 128'(3'd3));
    chk("full_ovf", 128'(ovf), 128'(1'b1));
    chk("full_ip",  128'(iq.ip), 128'(32'h404));
    chk("full_rdy", 128'(dec_rdy), 128'(1'b1));

    // Flush beats enqueue and dequeue
    flush = 1'b1; dec_v = 1'b1; dec = mk(32'h500, 3'd0); iq_rdy = 1'b1;
    step();
    flush = 1'b0; dec_v = 1'b0; iq_rdy = 1'b0;
    chk("flush_cnt", 128'(cnt), 128'(3'd0));
    chk("flush_v",   128'(iq_v), 128'(1'b0));
    chk("flush_rdy", 128'(dec_rdy), 128'(1'b1));
    step();
    chk("flush_nopres", 128'(iq_v), 128'(1'b0));

    do_reset();
    step();
    chk("rst2_ovf", 128'(ovf), 128'(1'b0));

    // Stale stream drop
    cur_stream = 3'd2;
    dec_v = 1'b1; dec = mk(32'h200, 3'd1);
    step();
    chk("stale_v", 128'(iq_v), 128'(1'b0));
    dec = mk(32'h204, 3'd2);
    step();
    dec_v = 1'b0;
    chk("stale_iq",  128'(iq), 128'(mk(32'h204, 3'd2)));
    chk("stale_cnt", 128'(cnt), 128'(3'd1));
    chk("stale_ovf", 128'(ovf), 128'(1'b0));
    iq_rdy = 1'b1;
    step();
    chk("stale_drain", 128'(iq_v), 128'(1'b0));

    // Wrap pointers with two entries resident
    iq_rdy = 1'b0; dec_v = 1'b1;
    dec = mk(32'h600, 3'd2); step();
    dec = mk(32'h604, 3'd2); step();
    chk("wrap_pre", 128'(cnt), 128'(3'd2));
    iq_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dec = mk(32'h600 + 32'(4*(i+2)), 3'd2);
      step();
      chk("wrap_ip",  128'(iq.ip), 128'(32'h600 + 32'(4*(i+1))));
      chk("wrap_cnt", 128'(cnt), 128'(3'd2));
    end
    dec_v = 1'b0; iq_rdy = 1'b0;

    // Async reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("arst_v",   128'(iq_v), 128'(1'b0));
    chk("arst_cnt", 128'(cnt), 128'(3'd0));
    chk("arst_rdy", 128'(dec_rdy), 128'(1'b1));
    #10;
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
